// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped IO target for the MEM stage io_* port.
// Owns the LED register, debounced switches/buttons and an 8-digit 7-seg scanner.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   io_addr         - byte address; hit when io_addr[31:5] == IO_BASE[31:5], select = io_addr[4:2]
//   io_write_data   - store data, committed on the rising edge when io_we is high
//   io_we           - store strobe
//   io_read_data    - combinational load data (0 on miss or on a reserved/absent register)
//   sw_in, btn_in   - raw asynchronous switches/buttons (2-FF sync + per-bit debounce)
//   led_out         - LED drive, active-high
//   seg_an, seg_cat - 7-seg anodes / segments {dp,g..a}, active-low, registered
//
// Register map: 0 LED, 1 SW, 2 BTN, 3 SEG_DATA, 4 SEG_MASK, 5 TIMER, 6-7 reserved.
// Build option: define MMIO_TIMER_EN to make register 5 a free-running cycle counter
// (any write clears it); otherwise register 5 reads 0 and writes are ignored.
module mmio_ctrl #(
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FC00,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [16:0] SCAN_DIV        = 17'd100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_write_data,
    input  logic        io_we,
    output logic [31:0] io_read_data,
    input  logic [15:0] sw_in,
    input  logic [4:0]  btn_in,
    output logic [15:0] led_out,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int unsigned NIN = 21;  // 16 switches + 5 buttons

    logic        hit;
    logic [2:0]  sel;
    logic        wr;
    logic [15:0] led_reg;
    logic [31:0] seg_data;
    logic [7:0]  seg_mask;
    logic [31:0] timer_rd;

    // Byte offset bits are don't-care for word-wide registers.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^io_addr[1:0];

    assign hit = (io_addr[31:5] == IO_BASE[31:5]);
    assign sel = io_addr[4:2];
    assign wr  = io_we && hit;

    // ---------------- writable registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg  <= '0;
            seg_data <= '0;
            seg_mask <= '0;
        end else if (wr) begin
            case (sel)
                3'd0:    led_reg  <= io_write_data[15:0];
                3'd3:    seg_data <= io_write_data;
                3'd4:    seg_mask <= io_write_data[7:0];
                default: ;
            endcase
        end
    end

    assign led_out = led_reg;

    // ---------------- input synchronizer + debouncer ----------------
    logic [NIN-1:0] sync1;
    logic [NIN-1:0] sync2;
    logic [NIN-1:0] accepted;
    logic [19:0]    db_cnt [NIN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            accepted <= '0;
            for (int unsigned i = 0; i < NIN; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_in, sw_in};
            sync2 <= sync1;
            for (int unsigned i = 0; i < NIN; i++) begin
                if (sync2[i] == accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    accepted[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    // ---------------- optional cycle timer ----------------
`ifdef MMIO_TIMER_EN
    logic [31:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timer <= '0;
        else if (wr && sel == 3'd5)
            timer <= '0;
        else
            timer <= timer + 32'd1;
    end

    assign timer_rd = timer;
`else
    assign timer_rd = '0;
`endif

    // ---------------- combinational read mux ----------------
    always_comb begin
        io_read_data = '0;
        if (hit) begin
            case (sel)
                3'd0:    io_read_data = {16'h0, led_reg};
                3'd1:    io_read_data = {16'h0, accepted[15:0]};
                3'd2:    io_read_data = {27'h0, accepted[20:16]};
                3'd3:    io_read_data = seg_data;
                3'd4:    io_read_data = {24'h0, seg_mask};
                3'd5:    io_read_data = timer_rd;
                default: io_read_data = '0;
            endcase
        end
    end

    // ---------------- 7-seg scanner ----------------
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    logic [16:0] scan_cnt;
    logic [2:0]  digit_idx;
    logic [3:0]  nibble;

    assign nibble = seg_data[{digit_idx, 2'b00} +: 4];

    // Outputs are registered from the current index, so they trail it by one cycle
    // and never show a half-updated anode/segment combination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            seg_an    <= '1;
            seg_cat   <= '1;
        end else begin
            if (scan_cnt == SCAN_DIV - 17'd1) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 17'd1;
            end
            if (seg_mask[digit_idx]) begin
                seg_an  <= ~(8'b1 << digit_idx);
                seg_cat <= {1'b1, hex_decode(nibble)};
            end else begin
                seg_an  <= '1;
                seg_cat <= '1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
module tb_mmio_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_addr = '0;
    logic [31:0] io_write_data = '0;
    logic        io_we = 1'b0;
    logic [31:0] io_read_data;
    logic [15:0] sw_in = '0;
    logic [4:0]  btn_in = '0;
    logic [15:0] led_out;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    mmio_ctrl #(
        .IO_BASE        (32'hFFFF_FC00),
        .DEBOUNCE_CYCLES(20'd4),
        .SCAN_DIV       (17'd4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_addr      (io_addr),
        .io_write_data(io_write_data),
        .io_we        (io_we),
        .io_read_data (io_read_data),
        .sw_in        (sw_in),
        .btn_in       (btn_in),
        .led_out      (led_out),
        .seg_an       (seg_an),
        .seg_cat      (seg_cat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        io_addr = a;
        io_write_data = d;
        io_we = 1'b1;
        tick();
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        io_addr = a;
        #1;
        d = io_read_data;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wr(BASE, 32'h0000_1234);
        wr(BASE + 32'h10, 32'h0000_00FF);
        wr(BASE + 32'h0C, 32'h1111_1111);
        repeat (6) tick();
        // assert reset between edges, mid-scan
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (led_out !== 16'h0) $display("FAIL reset_led: got %h expected %h", led_out, 16'h0);
        else pass_cnt++;
        total_cnt++;
        if (seg_an !== 8'hFF) $display("FAIL reset_an: got %h expected %h", seg_an, 8'hFF);
        else pass_cnt++;
        total_cnt++;
        if (seg_cat !== 8'hFF) $display("FAIL reset_cat: got %h expected %h", seg_cat, 8'hFF);
        else pass_cnt++;
        for (int r = 0; r < 6; r++) begin
            rd(BASE + 32'(r * 4), d);
            total_cnt++;
            if (d !== 32'h0) $display("FAIL reset_read%0d: got %h expected %h", r, d, 32'h0);
            else pass_cnt++;
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_led();
        logic [31:0] d;
        io_addr = BASE;
        io_write_data = 32'h0000_A5A5;
        io_we = 1'b1;
        #1;
        total_cnt++;
        if (io_read_data !== 32'h0) $display("FAIL led_same_cycle_old: got %h expected %h", io_read_data, 32'h0);
        else pass_cnt++;
        tick();
        io_we = 1'b0;
        total_cnt++;
        if (led_out !== 16'hA5A5) $display("FAIL led_out: got %h expected %h", led_out, 16'hA5A5);
        else pass_cnt++;
        rd(BASE, d);
        total_cnt++;
        if (d !== 32'h0000_A5A5) $display("FAIL led_read: got %h expected %h", d, 32'h0000_A5A5);
        else pass_cnt++;
        rd(BASE + 32'h1, d);
        total_cnt++;
        if (d !== 32'h0000_A5A5) $display("FAIL led_read_lsb: got %h expected %h", d, 32'h0000_A5A5);
        else pass_cnt++;
        tick();
        wr(BASE, 32'hFFFF_5A3C);
        total_cnt++;
        if (led_out !== 16'h5A3C) $display("FAIL led_out2: got %h expected %h", led_out, 16'h5A3C);
        else pass_cnt++;
        rd(BASE, d);
        total_cnt++;
        if (d !== 32'h0000_5A3C) $display("FAIL led_read_upper_zero: got %h expected %h", d, 32'h0000_5A3C);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        io_addr = BASE + 32'h4;
        sw_in = 16'h00F0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            d = io_read_data;
            total_cnt++;
            if (d !== ((c < 6) ? 32'h0 : 32'h0000_00F0))
                $display("FAIL sw_latency_c%0d: got %h expected %h", c, d, (c < 6) ? 32'h0 : 32'h0000_00F0);
            else pass_cnt++;
        end
        wr(BASE + 32'h4, 32'h0000_FFFF);
        rd(BASE + 32'h4, d);
        total_cnt++;
        if (d !== 32'h0000_00F0) $display("FAIL sw_ro: got %h expected %h", d, 32'h0000_00F0);
        else pass_cnt++;
        // short glitch must be rejected
        io_addr = BASE + 32'h8;
        btn_in = 5'b00001;
        repeat (2) tick();
        btn_in = 5'b00000;
        for (int c = 0; c < 8; c++) begin
            tick();
            total_cnt++;
            if (io_read_data !== 32'h0) $display("FAIL btn_glitch_c%0d: got %h expected %h", c, io_read_data, 32'h0);
            else pass_cnt++;
        end
        // held press accepted after 6 cycles
        btn_in = 5'b10000;
        for (int c = 1; c <= 6; c++) begin
            tick();
            total_cnt++;
            if (io_read_data !== ((c < 6) ? 32'h0 : 32'h0000_0010))
                $display("FAIL btn_hold_c%0d: got %h expected %h", c, io_read_data, (c < 6) ? 32'h0 : 32'h0000_0010);
            else pass_cnt++;
        end
        btn_in = 5'b00000;
        sw_in = 16'h0000;
        repeat (8) tick();
    endtask

    task automatic test_scan_mask();
        int n_fe;
        int n_fb;
        n_fe = 0;
        n_fb = 0;
        wr(BASE + 32'h0C, 32'h8765_4321);
        wr(BASE + 32'h10, 32'h0000_0005);
        tick();
        for (int c = 0; c < 64; c++) begin
            tick();
            total_cnt++;
            if (seg_an == 8'hFE) begin
                n_fe++;
                if (seg_cat !== 8'hF9) $display("FAIL scan05_d0_cat: got %h expected %h", seg_cat, 8'hF9);
                else pass_cnt++;
            end else if (seg_an == 8'hFB) begin
                n_fb++;
                if (seg_cat !== 8'hB0) $display("FAIL scan05_d2_cat: got %h expected %h", seg_cat, 8'hB0);
                else pass_cnt++;
            end else begin
                if (seg_an !== 8'hFF || seg_cat !== 8'hFF)
                    $display("FAIL scan05_dark: got an=%h cat=%h expected an=ff cat=ff", seg_an, seg_cat);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (n_fe !== 8) $display("FAIL scan05_d0_count: got %0d expected %0d", n_fe, 8);
        else pass_cnt++;
        total_cnt++;
        if (n_fb !== 8) $display("FAIL scan05_d2_count: got %0d expected %0d", n_fb, 8);
        else pass_cnt++;
    endtask

    task automatic test_scan_all();
        logic [31:0] data_list [2] = '{32'h7654_3210, 32'hFEDC_BA98};
        logic [31:0] data;
        logic [7:0]  seen;
        logic [7:0]  exp_cat;
        int idx;
        int prev;
        wr(BASE + 32'h10, 32'h0000_00FF);
        for (int p = 0; p < 2; p++) begin
            data = data_list[p];
            wr(BASE + 32'h0C, data);
            tick();
            seen = '0;
            prev = -1;
            for (int c = 0; c < 32; c++) begin
                tick();
                idx = -1;
                for (int k = 0; k < 8; k++)
                    if (seg_an == ~(8'b1 << k)) idx = k;
                total_cnt++;
                if (idx < 0) begin
                    $display("FAIL scanall_an: got %h expected one-hot-low", seg_an);
                end else begin
                    exp_cat = {1'b1, hex_tab[data[idx*4 +: 4]]};
                    if (seg_cat !== exp_cat)
                        $display("FAIL scanall_cat_d%0d: got %h expected %h", idx, seg_cat, exp_cat);
                    else if (prev >= 0 && idx != prev && idx != ((prev + 1) % 8))
                        $display("FAIL scanall_order: got %0d expected %0d", idx, (prev + 1) % 8);
                    else pass_cnt++;
                    seen[idx] = 1'b1;
                    prev = idx;
                end
            end
            total_cnt++;
            if (seen !== 8'hFF) $display("FAIL scanall_digits_seen: got %h expected %h", seen, 8'hFF);
            else pass_cnt++;
        end
        wr(BASE + 32'h10, 32'h0);
        tick();
        total_cnt++;
        if (seg_an !== 8'hFF || seg_cat !== 8'hFF)
            $display("FAIL scan_masked_off: got an=%h cat=%h expected an=ff cat=ff", seg_an, seg_cat);
        else pass_cnt++;
    endtask

    task automatic test_miss();
        logic [31:0] d;
        wr(BASE + 32'h0C, 32'hCAFE_F00D);
        wr(BASE, 32'h0000_7E57);
        rd(32'h1000_0000, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL miss_read: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        rd(BASE + 32'h18, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reserved_read: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        tick();
        rd(BASE + 32'h20, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL next_window_read: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        tick();
        wr(32'h1000_0000, 32'hDEAD_BEEF);
        wr(32'h1000_000C, 32'hDEAD_BEEF);
        wr(BASE + 32'h18, 32'hDEAD_BEEF);
        wr(BASE + 32'h1C, 32'hDEAD_BEEF);
        wr(BASE + 32'h20, 32'hDEAD_BEEF);
        total_cnt++;
        if (led_out !== 16'h7E57) $display("FAIL miss_led_kept: got %h expected %h", led_out, 16'h7E57);
        else pass_cnt++;
        rd(BASE + 32'h0C, d);
        total_cnt++;
        if (d !== 32'hCAFE_F00D) $display("FAIL miss_segdata_kept: got %h expected %h", d, 32'hCAFE_F00D);
        else pass_cnt++;
        rd(BASE + 32'h10, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL miss_segmask_kept: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_timer();
        logic [31:0] t0;
        logic [31:0] t1;
`ifdef MMIO_TIMER_EN
        rd(BASE + 32'h14, t0);
        repeat (10) tick();
        rd(BASE + 32'h14, t1);
        total_cnt++;
        if (t1 - t0 !== 32'd10) $display("FAIL timer_delta: got %0d expected %0d", t1 - t0, 10);
        else pass_cnt++;
        tick();
        wr(BASE + 32'h14, 32'h0);
        rd(BASE + 32'h14, t0);
        total_cnt++;
        if (t0 !== 32'd0) $display("FAIL timer_cleared: got %h expected %h", t0, 32'd0);
        else pass_cnt++;
        tick();
        rd(BASE + 32'h14, t1);
        total_cnt++;
        if (t1 !== 32'd1) $display("FAIL timer_resume: got %h expected %h", t1, 32'd1);
        else pass_cnt++;
`else
        rd(BASE + 32'h14, t0);
        total_cnt++;
        if (t0 !== 32'd0) $display("FAIL timer_absent: got %h expected %h", t0, 32'd0);
        else pass_cnt++;
        wr(BASE + 32'h14, 32'h1234_5678);
        repeat (5) tick();
        rd(BASE + 32'h14, t1);
        total_cnt++;
        if (t1 !== 32'd0) $display("FAIL timer_absent_write: got %h expected %h", t1, 32'd0);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_led();
        test_debounce();
        test_scan_mask();
        test_scan_all();
        test_miss();
        test_timer();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
